// File: rtl/divider_seq.sv
// Sequential restoring divider with valid/ready handshakes on both sides.
// Produces quotient and remainder, unsigned or signed (C truncation), STEP bits per cycle.
module divider_seq #(
    parameter int unsigned DW   = 16,
    parameter int unsigned VW   = 8,
    parameter int unsigned STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    input  logic          signed_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int unsigned NCYC = DW / STEP;
    localparam int unsigned CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t        state;
    logic [DW-1:0] a_q;
    logic [VW-1:0] b_q;
    logic [VW:0]   rem_q;
    logic [CW-1:0] cnt;
    logic          sign_a;
    logic          sign_b;
    logic          dz_q;

    logic [DW-1:0] a_abs;
    logic [VW-1:0] b_abs;
    logic [DW-1:0] a_n;
    logic [VW:0]   rem_n;

    always_comb begin
        a_abs = (signed_mode && dividend[DW-1]) ? -dividend : dividend;
        b_abs = (signed_mode && divisor[VW-1])  ? -divisor  : divisor;
    end

    // a_q doubles as the quotient shift register: dividend bits leave at the MSB
    // while quotient bits enter at the LSB.
    always_comb begin
        rem_n = rem_q;
        a_n   = a_q;
        for (int unsigned i = 0; i < STEP; i++) begin
            rem_n = {rem_n[VW-1:0], a_n[DW-1]};
            a_n   = {a_n[DW-2:0], 1'b0};
            if (rem_n >= {1'b0, b_q}) begin
                rem_n  = rem_n - {1'b0, b_q};
                a_n[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Zero divisor passes through CALC for one cycle so its result
                        // appears one cycle after the accept edge.
                        state    <= CALC;
                        in_ready <= 1'b0;
                        dz_q     <= (divisor == '0);
                        a_q      <= a_abs;
                        b_q      <= b_abs;
                        rem_q    <= '0;
                        cnt      <= '0;
                        sign_a   <= signed_mode & dividend[DW-1];
                        sign_b   <= signed_mode & divisor[VW-1];
                    end
                end
                CALC: begin
                    if (dz_q) begin
                        quotient    <= '1;
                        remainder   <= '0;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        a_q   <= a_n;
                        rem_q <= rem_n;
                        cnt   <= cnt + 1'b1;
                        if (cnt == CW'(NCYC - 1)) begin
                            quotient    <= (sign_a ^ sign_b) ? -a_n : a_n;
                            remainder   <= sign_a ? -rem_n[VW-1:0] : rem_n[VW-1:0];
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: three instances (STEP = 1, 2, 4) share one operand stream
// and are checked against an arithmetic reference model.
module tb_divider_seq;

    localparam int unsigned DW = 16;
    localparam int unsigned VW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic signed_mode;

    logic [2:0]         in_ready_a;
    logic [2:0]         out_valid_a;
    logic [2:0]         dz_a;
    logic [2:0][DW-1:0] q_a;
    logic [2:0][VW-1:0] r_a;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        divider_seq #(.DW(DW), .VW(VW), .STEP(1 << g)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .in_ready   (in_ready_a[g]),
            .dividend   (dividend),
            .divisor    (divisor),
            .signed_mode(signed_mode),
            .out_valid  (out_valid_a[g]),
            .out_ready  (out_ready),
            .quotient   (q_a[g]),
            .remainder  (r_a[g]),
            .div_by_zero(dz_a[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // C semantics: truncate toward zero, remainder carries the dividend's sign.
    function automatic void model(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                  input logic sm, output logic [DW-1:0] q,
                                  output logic [VW-1:0] r, output logic dz);
        longint la, lb, lq, lr;
        if (b == '0) begin
            q = '1; r = '0; dz = 1'b1;
        end else if (!sm) begin
            q  = a / DW'(b);
            r  = VW'(a % DW'(b));
            dz = 1'b0;
        end else begin
            la = longint'($signed(a));
            lb = longint'($signed(b));
            lq = la / lb;
            lr = la % lb;
            q  = lq[DW-1:0];
            r  = lr[VW-1:0];
            dz = 1'b0;
        end
    endfunction

    task automatic accept(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic sm);
        in_valid    = 1'b1;
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("accept_ready", 32'(in_ready_a), 32'h0);
    endtask

    task automatic wait_results(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic sm);
        int lat[3];
        logic [DW-1:0] eq;
        logic [VW-1:0] er;
        logic edz;
        lat = '{0, 0, 0};
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++)
                if (out_valid_a[g] && lat[g] == 0) lat[g] = k;
        end
        model(a, b, sm, eq, er, edz);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("lat%0d", g), 32'(lat[g]), (b == '0) ? 32'd1 : 32'(DW >> g));
            chk($sformatf("quo%0d", g), 32'(q_a[g]), 32'(eq));
            chk($sformatf("rem%0d", g), 32'(r_a[g]), 32'(er));
            chk($sformatf("dz%0d", g), 32'(dz_a[g]), 32'(edz));
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("hs_in_ready", 32'(in_ready_a), 32'h7);
        chk("hs_out_valid", 32'(out_valid_a), 32'h0);
    endtask

    task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input logic sm);
        accept(a, b, sm);
        wait_results(a, b, sm);
        handshake();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_a), 32'h7);
        chk({tag, "_out_valid"}, 32'(out_valid_a), 32'h0);
        chk({tag, "_dz"}, 32'(dz_a), 32'h0);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_quo%0d", tag, g), 32'(q_a[g]), 32'h0);
            chk($sformatf("%s_rem%0d", tag, g), 32'(r_a[g]), 32'h0);
        end
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;
        logic rs;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0; signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'd1000, 8'd7, 1'b0);
        run_op(16'h1234, 8'h00, 1'b0);
        run_op(16'd5, 8'd9, 1'b0);
        run_op(16'hFFF9, 8'h02, 1'b1);
        run_op(16'h8000, 8'hFF, 1'b1);
        run_op(16'h0064, 8'h80, 1'b1);
        run_op(16'hFFFF, 8'hFF, 1'b0);
        run_op(16'h8000, 8'h00, 1'b1);

        // Backpressure: results held, new operands refused until after the handshake.
        accept(16'd1000, 8'd7, 1'b0);
        wait_results(16'd1000, 8'd7, 1'b0);
        in_valid = 1'b1; dividend = 16'd200; divisor = 8'd3; signed_mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready_a), 32'h0);
            chk("bp_out_valid", 32'(out_valid_a), 32'h7);
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("bp_quo%0d", g), 32'(q_a[g]), 32'd142);
                chk($sformatf("bp_rem%0d", g), 32'(r_a[g]), 32'd6);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_hs_in_ready", 32'(in_ready_a), 32'h7);
        chk("bp_hs_out_valid", 32'(out_valid_a), 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept", 32'(in_ready_a), 32'h0);
        wait_results(16'd200, 8'd3, 1'b0);
        handshake();

        // Reset during the 8th CALC cycle.
        accept(16'h4321, 8'h13, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        chk("mid_no_valid", 32'(out_valid_a[1:0]), 32'h0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h4321, 8'h13, 1'b0);

        for (int n = 0; n < 1500; n++) begin
            ra = DW'($urandom);
            case ($urandom_range(0, 19))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = 8'h80;
                default: rb = VW'($urandom);
            endcase
            if ($urandom_range(0, 19) == 0) ra = 16'h8000;
            rs = 1'($urandom);
            run_op(ra, rb, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
